dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 119 +++++++++++
 tb/tb_dmem_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// ============================================================================
//  Module   : dmem_resp
//  Brief    : Single-outstanding data-memory responder with fixed response latency.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_resp_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int dmem_depth = 10,
    parameter int resp_lat   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out
);

    localparam int         C_WORDS = 2 ** dmem_depth;
    localparam logic [3:0] C_LOAD  = (resp_lat > 1) ? 4'(resp_lat - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [C_WORDS] = '{default: '0};

    logic                    accept;
    logic                    is_fence;
    logic                    is_write;
    logic                    is_read;
    logic [dmem_depth-1:0]   idx;
    logic                    unused_bits;

    assign accept   = (state_q == IDLE) && dmem_in.mem_valid;
    assign is_fence = dmem_in.mem_fence;
    assign is_write = !is_fence && (dmem_in.mem_wstrb != 4'd0);
    assign is_read  = !is_fence && (dmem_in.mem_wstrb == 4'd0);
    assign idx      = dmem_in.mem_addr[dmem_depth+1:2];

    // Upper address bits alias onto the array; byte offset and instr flag carry no meaning here.
    assign unused_bits = ^{dmem_in.mem_instr, dmem_in.mem_addr[31:dmem_depth+2],
                           dmem_in.mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (resp_lat == 1) ? RESP : BUSY;
                    cnt_d   = C_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rdata_q <= is_read ? mem_q[idx] : 32'd0;
            end
        end
    end

    // The array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && accept && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_in.mem_wstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= dmem_in.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign dmem_out.mem_ready = (state_q == RESP);
    assign dmem_out.mem_rdata = (state_q == RESP) ? rdata_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
//  Module   : tb_dmem_resp
//  Brief    : Self-checking bench for dmem_resp (transaction-level memory model).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mem_in_type  in2, in1, in3;
    mem_out_type out2, out1, out3;

    int total = 0;
    int bad   = 0;

    logic [31:0] mm [1024];

    typedef struct {
        logic        f;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    dmem_resp #(.dmem_depth(10), .resp_lat(2)) u_dut2 (.clk(clk), .rst(rst), .dmem_in(in2), .dmem_out(out2));
    dmem_resp #(.dmem_depth(10), .resp_lat(1)) u_dut1 (.clk(clk), .rst(rst), .dmem_in(in1), .dmem_out(out1));
    dmem_resp #(.dmem_depth(10), .resp_lat(3)) u_dut3 (.clk(clk), .rst(rst), .dmem_in(in3), .dmem_out(out3));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic do_req(input logic f, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] got);
        logic [31:0] exp;
        logic [9:0]  ix;
        int          n;
        ix = a[11:2];
        if (f) begin
            exp = 32'd0;
        end else if (ws != 4'd0) begin
            for (int i = 0; i < 4; i++)
                if (ws[i]) mm[ix][8*i +: 8] = wd[8*i +: 8];
            exp = 32'd0;
        end else begin
            exp = mm[ix];
        end
        @(negedge clk);
        in2.mem_valid = 1'b1;
        in2.mem_fence = f;
        in2.mem_addr  = a;
        in2.mem_wdata = wd;
        in2.mem_wstrb = ws;
        n = 0;
        do begin
            @(negedge clk);
            in2.mem_valid = 1'b0;
            n++;
            if (!out2.mem_ready) chk("rdata_when_not_ready", out2.mem_rdata, 32'd0);
        end while (!out2.mem_ready && n < 20);
        chk("latency", 32'(n), 32'(LAT));
        got = out2.mem_rdata;
        chk("model_rdata", got, exp);
        @(negedge clk);
        chk("ready_width", {31'd0, out2.mem_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] ra, rw;
        logic [3:0]  rs;
        logic        rf;

        for (int i = 0; i < 1024; i++) mm[i] = 32'd0;
        in2 = '0;
        in1 = '0;
        in3 = '0;
        in1.mem_valid = 1'b1;
        in3.mem_valid = 1'b1;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDE22_BE44};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_1010, 32'h0000_0000, 4'h0, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hCAFE_F00D};
        vecs[8] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 32'hCAFE_F00D};
        vecs[9] = '{1'b0, 32'h0000_0800, 32'h0000_0000, 4'h0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, out2.mem_ready}, 32'd0);
        chk("reset_rdata", out2.mem_rdata, 32'd0);

        // Release reset with valid held on the lat=1/lat=3 instances: first accept is cycle 0.
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("cont_lat1_ready", {31'd0, out1.mem_ready}, {31'd0, (c % 2) == 1});
            chk("cont_lat3_ready", {31'd0, out3.mem_ready},
                {31'd0, (c >= 3) && (((c - 3) % 4) == 0)});
            chk("cont_lat1_rdata", out1.mem_rdata, 32'd0);
        end

        foreach (vecs[i]) begin
            do_req(vecs[i].f, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, got);
            chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
        end

        // mem_valid during BUSY must be ignored, not queued.
        @(negedge clk);
        in2 = '0;
        in2.mem_valid = 1'b1;
        in2.mem_addr  = 32'h40;
        @(negedge clk);
        in2.mem_addr  = 32'h40;
        in2.mem_wdata = 32'hA5A5_A5A5;
        in2.mem_wstrb = 4'hF;
        @(negedge clk);
        in2 = '0;
        chk("busy_ignore_ready", {31'd0, out2.mem_ready}, 32'd1);
        chk("busy_ignore_rdata", out2.mem_rdata, mm[10'h10]);
        @(negedge clk);
        chk("busy_ignore_single", {31'd0, out2.mem_ready}, 32'd0);
        do_req(1'b0, 32'h40, 32'd0, 4'h0, got);

        // Reset one cycle after accepting a read kills the response; memory survives.
        do_req(1'b0, 32'h20, 32'h1234_5678, 4'hF, got);
        @(negedge clk);
        in2 = '0;
        in2.mem_valid = 1'b1;
        in2.mem_addr  = 32'h20;
        @(negedge clk);
        in2 = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rst_busy_no_ready", {31'd0, out2.mem_ready}, 32'd0);
            @(negedge clk);
        end

        // A write presented together with rst must not be accepted.
        in2.mem_valid = 1'b1;
        in2.mem_addr  = 32'h20;
        in2.mem_wdata = 32'hFFFF_FFFF;
        in2.mem_wstrb = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        in2 = '0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rst_valid_no_ready", {31'd0, out2.mem_ready}, 32'd0);
            @(negedge clk);
        end
        do_req(1'b0, 32'h20, 32'd0, 4'h0, got);
        chk("mem_kept_after_rst", got, 32'h1234_5678);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom & 32'hFFFF_F03F;
            rw = $urandom;
            rf = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req(rf, ra, rw, rs, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
